// File: rtl/pending_enc_pkg.sv
// Shared widths, reset constants and FSM encoding for pending_encoder_32x5.
// Build option: PENDING_ENC_ROUND_ROBIN_EN selects round-robin arbitration.
package pending_enc_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    localparam logic [IDX_W-1:0] IDX_RST = '0;
    localparam logic [IDX_W-1:0] PTR_RST = '0;

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } enc_state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pending_encoder_32x5_encoder.sv
// Combinational 32-to-5 encoder: index of first set bit plus any-set flag.
// Ports: vec_i vector, base_i search start (round-robin build only),
// idx_o selected index, any_o vector non-zero.
// Build option: PENDING_ENC_ROUND_ROBIN_EN adds base_i.
module pending_encoder_32x5_encoder
    import pending_enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
`ifdef PENDING_ENC_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] base_i,
`endif
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] enc;

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    logic [2*N_REQ-1:0] dbl;

    // Rotate right so base_i lands on bit 0; the wrap comes from the copy.
    always_comb begin
        dbl = {vec_i, vec_i} >> base_i;
        rot = dbl[N_REQ-1:0];
    end
`else
    assign rot = vec_i;
`endif

    // Descending scan: the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    assign idx_o = enc + base_i;
`else
    assign idx_o = enc;
`endif

    assign any_o = |vec_i;

endmodule

// File: rtl/pending_encoder_32x5.sv
// Latches request pulses and offers one pending index per VALID/ACK transfer.
// Ports: CLK, RESET (async low), REQ[31:0], ACK in; IDX[4:0], VALID,
// PENDING[31:0], OVERRUN out. Build option: PENDING_ENC_ROUND_ROBIN_EN.
module pending_encoder_32x5
    import pending_enc_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_REQ-1:0] REQ,
    input  logic             ACK,
    output logic [IDX_W-1:0] IDX,
    output logic             VALID,
    output logic [N_REQ-1:0] PENDING,
    output logic             OVERRUN
);

    enc_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             overrun_q, overrun_d;

    logic             xfer;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] rem;
    logic [IDX_W-1:0] pend_idx, rem_idx;
    logic             pend_any, rem_any;

    assign xfer = (state_q == S_OFFER) && ACK;
    assign clr  = xfer ? onehot(idx_q) : '0;
    // Selection after a transfer sees only the old vector, not REQ.
    assign rem  = pending_q & ~onehot(idx_q);

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // ptr_q holds the search start, i.e. last granted index + 1.
    assign ptr_d = xfer ? idx_q + IDX_W'(1) : ptr_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    pending_encoder_32x5_encoder u_enc_pend (
        .vec_i  (pending_q),
        .base_i (ptr_q),
        .idx_o  (pend_idx),
        .any_o  (pend_any)
    );

    // The rem search already uses the pointer this transfer will write.
    pending_encoder_32x5_encoder u_enc_rem (
        .vec_i  (rem),
        .base_i (idx_q + IDX_W'(1)),
        .idx_o  (rem_idx),
        .any_o  (rem_any)
    );
`else
    pending_encoder_32x5_encoder u_enc_pend (
        .vec_i  (pending_q),
        .idx_o  (pend_idx),
        .any_o  (pend_any)
    );

    pending_encoder_32x5_encoder u_enc_rem (
        .vec_i  (rem),
        .idx_o  (rem_idx),
        .any_o  (rem_any)
    );
`endif

    // Set wins over clear, so a same-cycle request re-arms the line.
    assign pending_d = (pending_q & ~clr) | REQ;
    assign overrun_d = overrun_q | (|(REQ & pending_q & ~clr));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            idx_q     <= IDX_RST;
            pending_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (pend_any) begin
                    state_d = S_OFFER;
                    idx_d   = pend_idx;
                end
            end
            S_OFFER: begin
                if (ACK) begin
                    if (rem_any) begin
                        idx_d = rem_idx;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        VALID   = (state_q == S_OFFER);
        IDX     = idx_q;
        PENDING = pending_q;
        OVERRUN = overrun_q;
    end

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// Self-checking bench for pending_encoder_32x5: directed steps plus random
// traffic against a behavioural model of the pending/offer rules.
module tb_pending_encoder_32x5;

    logic        CLK;
    logic        RESET;
    logic [31:0] REQ;
    logic        ACK;
    logic [4:0]  IDX;
    logic        VALID;
    logic [31:0] PENDING;
    logic        OVERRUN;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pend;
    int          m_idx;
    bit          m_valid;
    bit          m_ovr;
    int          m_start;

    pending_encoder_32x5 dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ     (REQ),
        .ACK     (ACK),
        .IDX     (IDX),
        .VALID   (VALID),
        .PENDING (PENDING),
        .OVERRUN (OVERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int pick(input logic [31:0] v, input int start);
        for (int k = 0; k < 32; k++) begin
            if (v[(start + k) % 32]) return (start + k) % 32;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_idx   = 0;
        m_valid = 0;
        m_ovr   = 0;
        m_start = 0;
    endtask

    task automatic model_tick(input logic [31:0] r, input bit a);
        int          clr;
        int          nxt;
        logic [31:0] rem;
        logic [31:0] np;
        clr = (m_valid && a) ? m_idx : -1;
        np = m_pend;
        if (clr >= 0) np[clr] = 1'b0;
        if ((r & np) != 0) m_ovr = 1;
        np = np | r;
        if (!m_valid) begin
            nxt = pick(m_pend, m_start);
            if (nxt >= 0) begin
                m_idx   = nxt;
                m_valid = 1;
            end
        end else if (a) begin
`ifdef PENDING_ENC_ROUND_ROBIN_EN
            m_start = (m_idx + 1) % 32;
`endif
            rem = m_pend;
            rem[m_idx] = 1'b0;
            nxt = pick(rem, m_start);
            if (nxt >= 0) m_idx = nxt;
            else m_valid = 0;
        end
        m_pend = np;
    endtask

    task automatic chk(input string tag);
        checks++;
        assert (VALID === m_valid) else begin
            errors++;
            $error("FAIL %s VALID got %0b exp %0b", tag, VALID, m_valid);
        end
        checks++;
        assert (IDX === 5'(m_idx)) else begin
            errors++;
            $error("FAIL %s IDX got %0d exp %0d", tag, IDX, m_idx);
        end
        checks++;
        assert (PENDING === m_pend) else begin
            errors++;
            $error("FAIL %s PENDING got %h exp %h", tag, PENDING, m_pend);
        end
        checks++;
        assert (OVERRUN === m_ovr) else begin
            errors++;
            $error("FAIL %s OVERRUN got %0b exp %0b", tag, OVERRUN, m_ovr);
        end
    endtask

    task automatic step(input logic [31:0] r, input bit a, input string tag);
        REQ = r;
        ACK = a;
        @(posedge CLK);
        model_tick(r, a);
        #1;
        chk(tag);
    endtask

    task automatic expect_idx(input int exp, input string tag);
        checks++;
        assert (VALID === 1'b1 && IDX === 5'(exp)) else begin
            errors++;
            $error("FAIL %s VALID/IDX got %0b/%0d exp 1/%0d",
                   tag, VALID, IDX, exp);
        end
    endtask

    task automatic expect_idle(input string tag);
        checks++;
        assert (VALID === 1'b0) else begin
            errors++;
            $error("FAIL %s VALID got %0b exp 0", tag, VALID);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_valid; i++) step('0, 1'b1, "drain");
        step('0, 1'b0, "drain_idle");
    endtask

    initial begin
        RESET = 1'b0;
        REQ   = '0;
        ACK   = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset");
        @(negedge CLK);
        RESET = 1'b1;

        for (int i = 0; i < 10; i++) step('0, 1'b0, "quiet");

        step(32'h0000_0100, 1'b1, "pulse8_e0");
        step('0, 1'b1, "pulse8_e1");
        expect_idx(8, "pulse8_idx");
        step('0, 1'b1, "pulse8_e2");
        expect_idle("pulse8_done");
        checks++;
        assert (PENDING === 32'h0) else begin
            errors++;
            $error("FAIL pulse8_pend got %h exp 0", PENDING);
        end

        step(32'h8000_0005, 1'b1, "prio_load");
        step('0, 1'b1, "prio_a");
        step('0, 1'b1, "prio_b");
        step('0, 1'b1, "prio_c");
        step('0, 1'b1, "prio_end");
        expect_idle("prio_idle");

        // Fixed-priority order check on a fresh burst.
`ifndef PENDING_ENC_ROUND_ROBIN_EN
        step(32'h8000_0005, 1'b1, "fixed_load");
        step('0, 1'b1, "fixed0");
        expect_idx(0, "fixed_seq0");
        step('0, 1'b1, "fixed2");
        expect_idx(2, "fixed_seq2");
        step('0, 1'b1, "fixed31");
        expect_idx(31, "fixed_seq31");
        step('0, 1'b1, "fixed_end");
        expect_idle("fixed_idle");
`else
        // Grant index 1 first so the search starts at 2.
        step(32'h0000_0002, 1'b0, "rr_pre");
        step('0, 1'b1, "rr_pre_offer");
        expect_idx(1, "rr_pre_idx");
        step(32'h8000_0005, 1'b1, "rr_load");
        expect_idle("rr_gap");
        step('0, 1'b1, "rr2");
        expect_idx(2, "rr_seq2");
        step('0, 1'b1, "rr31");
        expect_idx(31, "rr_seq31");
        step('0, 1'b1, "rr0");
        expect_idx(0, "rr_seq0");
        step('0, 1'b1, "rr_end");
        expect_idle("rr_idle");
`endif

        step(32'h0000_0010, 1'b0, "rearm_set");
        step('0, 1'b0, "rearm_offer");
        expect_idx(4, "rearm_idx");
        step(32'h0000_0010, 1'b1, "rearm_ack");
        checks++;
        assert (PENDING[4] === 1'b1 && OVERRUN === 1'b0) else begin
            errors++;
            $error("FAIL rearm_state got pend4=%0b ovr=%0b exp 1/0",
                   PENDING[4], OVERRUN);
        end
        step('0, 1'b0, "rearm_again");
        expect_idx(4, "rearm_idx2");
        drain();

        step(32'h0000_0008, 1'b0, "ovr_set");
        step('0, 1'b0, "ovr_offer");
        step(32'h0000_0008, 1'b0, "ovr_hit1");
        step(32'h0000_0008, 1'b0, "ovr_hit2");
        step('0, 1'b0, "ovr_hold");
        checks++;
        assert (OVERRUN === 1'b1) else begin
            errors++;
            $error("FAIL ovr_sticky got %0b exp 1", OVERRUN);
        end
        drain();
        step('0, 1'b0, "ovr_after_drain");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            bit          a;
            r = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) r = '0;
            a = ($urandom_range(0, 3) != 0);
            step(r, a, "rand");
        end

        step(32'h0000_0001, 1'b0, "mid_set");
        step('0, 1'b0, "mid_offer");
        ACK = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        chk("mid_reset");
        @(posedge CLK);
        #1;
        chk("mid_reset_edge");
        @(negedge CLK);
        RESET = 1'b1;
        step('0, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pending_encoder_32x5.md
# pending_encoder_32x5

Sequential 32-to-5 request encoder: latches one-shot request pulses into a 32-bit pending register and offers the index of one pending line at a time over a VALID/ACK handshake, clearing that line on acceptance. It is the inverse companion to the 5x32 line decoder. The typical use is to turn scattered event/interrupt lines into a 5-bit register or opcode index that downstream logic decodes back to one-hot.

## Interface
Parameters:
- none; widths are fixed at 32 request lines and a 5-bit index, taken from the shared package.

Ports:
- CLK      in   1   single clock; all state updates on the rising edge.
- RESET    in   1   asynchronous, active-low. RESET=0 clears all state immediately; release is synchronous to CLK.
- REQ      in   32  request pulses. Bit i high for one or more cycles sets pending[i].
- ACK      in   1   consumer accepts the current IDX; qualified by VALID.
- IDX      out  5   index of the offered request; registered; stable while VALID=1 and ACK=0.
- VALID    out  1   registered; IDX is meaningful.
- PENDING  out  32  registered pending vector, for status readback.
- OVERRUN  out  1   sticky flag: a request arrived on a line that was already pending and not being cleared. Cleared only by reset.

## Operation
- Pending update per bit: next pending[i] = (pending[i] AND NOT clr[i]) OR REQ[i].
  - clr = one-hot(IDX) when VALID AND ACK, else 0.
  - Set wins over clear in the same cycle, so the line is re-armed.
- OVERRUN sets when REQ[i] AND pending[i] AND NOT clr[i] for any i.
- Two-state FSM on VALID:
  - IDLE (VALID=0): if pending is non-zero, load IDX = select(pending) and go to OFFER; otherwise stay. ACK is ignored.
  - OFFER (VALID=1), ACK=0: hold IDX, stay.
  - OFFER (VALID=1), ACK=1: let rem = pending AND NOT one-hot(IDX).
    - If rem is non-zero: load IDX = select(rem) and stay in OFFER (back-to-back).
    - Otherwise go to IDLE.
    - Requests arriving in the ACK cycle are not visible to this selection.
- select(): fixed priority; the lowest-numbered set bit wins.
- Widths: the index is 5 bits unsigned; round-robin pointer arithmetic wraps modulo 32 (31+1 = 0).

## Timing
- Reset values: IDX=0, VALID=0, PENDING=0, OVERRUN=0, round-robin pointer=0.
- Reset asserted mid-offer drops VALID asynchronously; an ACK in that cycle is ignored.
- Request latency: REQ[i] sampled at edge n gives PENDING[i]=1 after edge n; VALID=1 with IDX=i after edge n+1 when no other line has priority.
- Handshake: a transfer occurs on an edge where VALID=1 and ACK=1.
  - The cleared bit is gone from PENDING after that edge.
  - The next IDX is presented after that same edge: sustained throughput is one grant per cycle, with no bubble.
- ACK held high continuously drains one line per cycle.

## Configuration
- PENDING_ENC_ROUND_ROBIN_EN defined:
  - select() searches upward starting at (last accepted IDX + 1) mod 32 and wraps past bit 31 to bit 0.
  - The pointer updates only on a transfer and resets to 0, so the search starts at bit 0.
- Undefined: fixed lowest-index priority and no pointer register.
- Port list is identical in both builds.

## Structure
- Package pending_enc_pkg holds N_REQ=32, IDX_W=5, and the reset constants for IDX and the pointer.
- Sub-module ENCODER_32x5: combinational, takes a 32-bit vector and produces a 5-bit lowest-set-bit index plus an any-set flag.
  - The round-robin build rotates the vector right by the pointer, encodes it, then adds the pointer modulo 32.
  - It is instantiated twice: once for pending, once for rem.

## Test plan
- Reset, then REQ=0x0000_0000 for 10 cycles -> VALID=0, IDX=0, PENDING=0, OVERRUN=0 throughout.
- Single pulse REQ=0x0000_0100 at edge 0, ACK tied high -> VALID=1, IDX=8 after edge 1; PENDING=0 and VALID=0 after edge 2.
- REQ=0x8000_0005 one cycle, ACK held high, fixed priority -> IDX sequence 0, 2, 31 on consecutive cycles, then VALID=0.
- Same stimulus with PENDING_ENC_ROUND_ROBIN_EN and pointer preset by a prior grant of index 1 -> sequence 2, 31, 0.
- VALID=1 with IDX=4, ACK=1 and REQ=0x0000_0010 in the same cycle -> PENDING[4] stays 1, OVERRUN stays 0, IDX=4 is offered again.
- REQ[3] pulsed twice while pending and ACK=0 -> OVERRUN=1 and stays 1.
- Assert RESET mid-offer -> all outputs return to their reset values.
